seq_detector_mealy: RTL

- Parametrised Mealy sequence detector: recognises a configurable N-bit serial pattern on a 1-bit input stream.
- Supports overlapping or non-overlapping matching, and an optional one-shot (lock-after-first-match) mode.
- Counts matches in a saturating counter.
- Successor to the fixed 4-bit detectors; sits between a serial input source and downstream control/status logic.

---
 rtl/seq_detector_mealy.sv | 76 +++++++
 1 files changed

// File: rtl/seq_detector_mealy.sv
// seq_detector_mealy: parametrised Mealy serial pattern detector with saturating match counter
module seq_detector_mealy #(
    parameter int N = 4,
    parameter logic [N-1:0] PATTERN = 4'b1101,
    parameter bit OVERLAP = 1'b1,
    parameter bit ONCE = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    input  logic                 x,
    output logic                 y,
    output logic                 locked,
    output logic [CNT_W-1:0]     match_count,
    output logic [$clog2(N)-1:0] state
);
    localparam int SW = $clog2(N);

    // Longest prefix of PATTERN that is a suffix of (prefix k followed by b), capped below N
    function automatic int extend(int k, bit b);
        int r;
        bit ok;
        bit c;
        r = 0;
        for (int j = 1; j < N; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    c = (k + 1 - j + t == k) ? b : PATTERN[N-1-(k+1-j+t)];
                    if (c != PATTERN[N-1-t]) ok = 1'b0;
                end
                if (ok) r = j;
            end
        end
        return r;
    endfunction

    function automatic logic [N*SW-1:0] table_for(bit b);
        logic [N*SW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*SW +: SW] = SW'(extend(k, b));
        return r;
    endfunction

    localparam logic [N*SW-1:0] NEXT0 = table_for(1'b0);
    localparam logic [N*SW-1:0] NEXT1 = table_for(1'b1);

    logic             legal, hit, lock_d;
    logic [SW-1:0]    step, state_d;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        legal   = int'(state) < N;
        step    = legal ? (x ? NEXT1[int'(state)*SW +: SW] : NEXT0[int'(state)*SW +: SW]) : '0;
        hit     = ~reset & en & ~clear & ~locked & legal & (int'(state) == N - 1) & (x == PATTERN[0]);
        state_d = clear | ~legal ? '0 : ~en | locked ? state : hit & (ONCE | ~OVERLAP) ? '0 : step;
        lock_d  = ONCE & ~clear & (locked | hit);
        count_d = clear ? '0 : hit & ~&match_count ? match_count + 1'b1 : match_count;
    end

    assign y = hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= '0;
            locked      <= 1'b0;
            match_count <= '0;
        end else begin
            state       <= state_d;
            locked      <= lock_d;
            match_count <= count_d;
        end
    end
endmodule
